// File: rtl/player_motion.sv
// player_motion: integrates horizontal step pulses into pos_x and runs the
// vertical jump/fall state machine (integer gravity) that drives pos_y.
// Optional feature macro: DOUBLE_JUMP_EN (one extra jump per airborne period).
module player_motion #(
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 623,
  parameter int CEIL_Y    = 0,
  parameter int FLOOR_Y   = 447,
  parameter int SPAWN_X   = 32,
  parameter int JUMP_V    = 8,
  parameter int MAX_FALL  = 10,
  parameter int VSTEP_DIV = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] is_move,
  input  logic       jump_key,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] air_state,
  output logic       landed
);

  localparam int                VW          = (VSTEP_DIV > 2) ? $clog2(VSTEP_DIV) : 1;
  localparam logic [VW-1:0]     VSTEP_LAST  = VW'(VSTEP_DIV - 1);
  localparam logic [9:0]        X_MIN_C     = 10'(X_MIN);
  localparam logic [9:0]        X_MAX_C     = 10'(X_MAX);
  localparam logic [9:0]        CEIL_C      = 10'(CEIL_Y);
  localparam logic [9:0]        FLOOR_C     = 10'(FLOOR_Y);
  localparam logic [9:0]        SPAWN_C     = 10'(SPAWN_X);
  localparam logic signed [10:0] CEIL_S     = 11'(CEIL_Y);
  localparam logic signed [10:0] FLOOR_S    = 11'(FLOOR_Y);
  localparam logic [3:0]        JUMP_V_C    = 4'(JUMP_V);
  localparam logic [3:0]        MAX_FALL_C  = 4'(MAX_FALL);

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_RISE   = 2'b10,
    ST_FALL   = 2'b11
  } state_e;

  // Gravity: fall speed grows by one per vertical step up to terminal speed.
  function automatic logic [3:0] sat_fall(input logic [3:0] v);
    logic [4:0] inc;
    inc = {1'b0, v} + 5'd1;
    if (inc >= {1'b0, MAX_FALL_C}) return MAX_FALL_C;
    else                           return inc[3:0];
  endfunction

  state_e         state_q, state_d;
  logic [9:0]     pos_x_q, pos_x_d;
  logic [9:0]     pos_y_q, pos_y_d;
  logic [3:0]     vel_q, vel_d;
  logic [VW-1:0]  vstep_q, vstep_d;
  logic           jump_q;
  logic           landed_q, landed_d;
  logic           vtick, jedge, air_jump;
  logic [3:0]     vel_fall;
  logic signed [10:0] y_rise, y_fall;
  logic           unused_move_bits;

  assign unused_move_bits = ^is_move[1:0];

  assign vtick    = (vstep_q == VSTEP_LAST);
  assign jedge    = jump_key & ~jump_q;
  assign vel_fall = sat_fall(vel_q);
  assign y_rise   = $signed({1'b0, pos_y_q}) - $signed({7'b0, vel_q});
  assign y_fall   = $signed({1'b0, pos_y_q}) + $signed({7'b0, vel_fall});

`ifdef DOUBLE_JUMP_EN
  logic dj_used_q, dj_used_d;
  assign air_jump = jedge & ~dj_used_q;
`else
  assign air_jump = 1'b0;
`endif

  // Horizontal step: opposing pulses cancel, bounds clamp.
  always_comb begin
    pos_x_d = pos_x_q;
    case (is_move[3:2])
      2'b10:   if (pos_x_q < X_MAX_C) pos_x_d = pos_x_q + 10'd1;
      2'b01:   if (pos_x_q > X_MIN_C) pos_x_d = pos_x_q - 10'd1;
      default: pos_x_d = pos_x_q;
    endcase
  end

  // Vertical-step divider: free-running, wraps at VSTEP_DIV-1.
  always_comb begin
    vstep_d = vtick ? '0 : vstep_q + 1'b1;
  end

  // Jump/fall next-state: a jump edge always beats a vertical step in the same cycle.
  always_comb begin
    state_d  = state_q;
    pos_y_d  = pos_y_q;
    vel_d    = vel_q;
    landed_d = 1'b0;
`ifdef DOUBLE_JUMP_EN
    dj_used_d = dj_used_q;
`endif
    case (state_q)
      ST_GROUND: begin
        if (jedge) begin
          state_d = ST_RISE;
          vel_d   = JUMP_V_C;
        end
      end
      ST_RISE: begin
        if (air_jump) begin
          state_d = ST_RISE;
          vel_d   = JUMP_V_C;
`ifdef DOUBLE_JUMP_EN
          dj_used_d = 1'b1;
`endif
        end else if (vtick) begin
          if (y_rise < CEIL_S) begin
            pos_y_d = CEIL_C;
            vel_d   = 4'd0;
            state_d = ST_FALL;
          end else begin
            pos_y_d = y_rise[9:0];
            vel_d   = vel_q - 4'd1;
            if (vel_q == 4'd1) state_d = ST_FALL;
          end
        end
      end
      ST_FALL: begin
        if (air_jump) begin
          state_d = ST_RISE;
          vel_d   = JUMP_V_C;
`ifdef DOUBLE_JUMP_EN
          dj_used_d = 1'b1;
`endif
        end else if (vtick) begin
          vel_d = vel_fall;
          if (y_fall >= FLOOR_S) begin
            pos_y_d  = FLOOR_C;
            vel_d    = 4'd0;
            state_d  = ST_GROUND;
            landed_d = 1'b1;
`ifdef DOUBLE_JUMP_EN
            dj_used_d = 1'b0;
`endif
          end else begin
            pos_y_d = y_fall[9:0];
          end
        end
      end
      default: state_d = ST_GROUND;
    endcase
  end

  // State registers; reset returns the player to spawn even mid-jump.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_GROUND;
      pos_x_q  <= SPAWN_C;
      pos_y_q  <= FLOOR_C;
      vel_q    <= 4'd0;
      vstep_q  <= '0;
      jump_q   <= 1'b0;
      landed_q <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      dj_used_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      pos_x_q  <= pos_x_d;
      pos_y_q  <= pos_y_d;
      vel_q    <= vel_d;
      vstep_q  <= vstep_d;
      jump_q   <= jump_key;
      landed_q <= landed_d;
`ifdef DOUBLE_JUMP_EN
      dj_used_q <= dj_used_d;
`endif
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign air_state = state_q;
  assign landed    = landed_q;

endmodule

// File: tb/tb_player_motion.sv
// Directed testbench for player_motion (VSTEP_DIV=4). A second instance with a
// low floor reaches the ceiling clamp. Honours DOUBLE_JUMP_EN for expectations.
module tb_player_motion;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] is_move = 4'b0000;
  logic       jump_key = 1'b0;
  logic [9:0] pos_x, pos_y, pos_x_c, pos_y_c;
  logic [1:0] air_state, air_state_c;
  logic       landed, landed_c;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef DOUBLE_JUMP_EN
  localparam logic [1:0] EXP_AIR_JUMP = 2'b10;
  localparam int         EXP_Y_AFTER  = 403;
`else
  localparam logic [1:0] EXP_AIR_JUMP = 2'b11;
  localparam int         EXP_Y_AFTER  = 412;
`endif

  always #5 clk = ~clk;

  player_motion #(.VSTEP_DIV(4)) dut (
    .clk(clk), .rst(rst), .is_move(is_move), .jump_key(jump_key),
    .pos_x(pos_x), .pos_y(pos_y), .air_state(air_state), .landed(landed)
  );

  player_motion #(.VSTEP_DIV(4), .FLOOR_Y(20)) dut_c (
    .clk(clk), .rst(rst), .is_move(is_move), .jump_key(jump_key),
    .pos_x(pos_x_c), .pos_y(pos_y_c), .air_state(air_state_c), .landed(landed_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; is_move = 4'b0000; jump_key = 1'b0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (pos_x !== 10'd32) begin n_bad++; $display("FAIL reset_pos_x: got %0d want 32", pos_x); end
    n_cmp++; if (pos_y !== 10'd447) begin n_bad++; $display("FAIL reset_pos_y: got %0d want 447", pos_y); end
    n_cmp++; if (air_state !== 2'b00) begin n_bad++; $display("FAIL reset_air: got %b want 00", air_state); end
    n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL reset_landed: got %b want 0", landed); end
    n_cmp++; if (pos_y_c !== 10'd20) begin n_bad++; $display("FAIL reset_pos_y_c: got %0d want 20", pos_y_c); end
  endtask

  task automatic test_horizontal();
    do_reset();
    is_move = 4'b1000; step(); is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd33) begin n_bad++; $display("FAIL right_latency: got %0d want 33", pos_x); end
    for (int i = 0; i < 4; i++) begin
      is_move = 4'b1000; step(); is_move = 4'b0000; step();
    end
    for (int i = 0; i < 2; i++) begin
      is_move = 4'b1100; step(); is_move = 4'b0000; step();
    end
    n_cmp++; if (pos_x !== 10'd37) begin n_bad++; $display("FAIL right_both: got %0d want 37", pos_x); end
    is_move = 4'b0011; step(); is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd37) begin n_bad++; $display("FAIL ignored_bits: got %0d want 37", pos_x); end
    is_move = 4'b0100; step(); is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd36) begin n_bad++; $display("FAIL left_one: got %0d want 36", pos_x); end
    is_move = 4'b0100;
    for (int i = 0; i < 40; i++) step();
    is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd0) begin n_bad++; $display("FAIL left_to_min: got %0d want 0", pos_x); end
    is_move = 4'b0100; step(); is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd0) begin n_bad++; $display("FAIL left_at_min: got %0d want 0", pos_x); end
    is_move = 4'b1000;
    for (int i = 0; i < 623; i++) step();
    is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd623) begin n_bad++; $display("FAIL right_to_max: got %0d want 623", pos_x); end
    is_move = 4'b1000; step(); is_move = 4'b0000;
    n_cmp++; if (pos_x !== 10'd623) begin n_bad++; $display("FAIL right_at_max: got %0d want 623", pos_x); end
  endtask

  task automatic test_jump();
    int exp_y [16] = '{439, 432, 426, 421, 417, 414, 412, 411,
                       412, 414, 417, 421, 426, 432, 439, 447};
    int idx = 0;
    int n_land = 0;
    logic [9:0] prev;
    logic [1:0] es;
    do_reset();
    jump_key = 1'b1; is_move = 4'b1000; step(); is_move = 4'b0000;
    n_cmp++; if (air_state !== 2'b10) begin n_bad++; $display("FAIL jump_start_air: got %b want 10", air_state); end
    n_cmp++; if (pos_y !== 10'd447) begin n_bad++; $display("FAIL jump_start_y: got %0d want 447", pos_y); end
    n_cmp++; if (pos_x !== 10'd33) begin n_bad++; $display("FAIL air_move_x: got %0d want 33", pos_x); end
    prev = pos_y;
    for (int c = 0; c < 200 && idx < 16; c++) begin
      step();
      if (landed) n_land++;
      if (pos_y !== prev) begin
        es = (idx < 7) ? 2'b10 : ((idx < 15) ? 2'b11 : 2'b00);
        n_cmp++; if (pos_y !== 10'(exp_y[idx])) begin n_bad++; $display("FAIL jump_y[%0d]: got %0d want %0d", idx, pos_y, exp_y[idx]); end
        n_cmp++; if (air_state !== es) begin n_bad++; $display("FAIL jump_air[%0d]: got %b want %b", idx, air_state, es); end
        n_cmp++; if (landed !== (idx == 15)) begin n_bad++; $display("FAIL jump_landed[%0d]: got %b want %b", idx, landed, idx == 15); end
        prev = pos_y;
        idx++;
      end
    end
    n_cmp++; if (idx != 16) begin n_bad++; $display("FAIL jump_timeout: got %0d steps want 16", idx); end
    for (int c = 0; c < 24; c++) begin
      step();
      if (landed) n_land++;
    end
    n_cmp++; if (n_land != 1) begin n_bad++; $display("FAIL landed_pulses: got %0d want 1", n_land); end
    n_cmp++; if (air_state !== 2'b00) begin n_bad++; $display("FAIL hold_no_rejump_air: got %b want 00", air_state); end
    n_cmp++; if (pos_y !== 10'd447) begin n_bad++; $display("FAIL hold_no_rejump_y: got %0d want 447", pos_y); end
    jump_key = 1'b0;
  endtask

  task automatic test_ceiling();
    int exp_y [9] = '{12, 5, 0, 1, 3, 6, 10, 15, 20};
    int idx = 0;
    logic [9:0] prev;
    logic [1:0] es;
    do_reset();
    jump_key = 1'b1; step(); jump_key = 1'b0;
    prev = pos_y_c;
    for (int c = 0; c < 120 && idx < 9; c++) begin
      step();
      if (pos_y_c !== prev) begin
        es = (idx < 2) ? 2'b10 : ((idx < 8) ? 2'b11 : 2'b00);
        n_cmp++; if (pos_y_c !== 10'(exp_y[idx])) begin n_bad++; $display("FAIL ceil_y[%0d]: got %0d want %0d", idx, pos_y_c, exp_y[idx]); end
        n_cmp++; if (air_state_c !== es) begin n_bad++; $display("FAIL ceil_air[%0d]: got %b want %b", idx, air_state_c, es); end
        prev = pos_y_c;
        idx++;
      end
    end
    n_cmp++; if (idx != 9) begin n_bad++; $display("FAIL ceil_timeout: got %0d steps want 9", idx); end
  endtask

  task automatic test_reset_mid_fall();
    do_reset();
    jump_key = 1'b1; is_move = 4'b1000; step(); jump_key = 1'b0; is_move = 4'b0000;
    for (int c = 0; c < 100 && air_state !== 2'b11; c++) step();
    n_cmp++; if (air_state !== 2'b11) begin n_bad++; $display("FAIL midfall_reach: got %b want 11", air_state); end
    n_cmp++; if (air_state_c !== 2'b11) begin n_bad++; $display("FAIL midfall_reach_c: got %b want 11", air_state_c); end
    rst = 1'b1; step(); rst = 1'b0;
    n_cmp++; if (air_state !== 2'b00) begin n_bad++; $display("FAIL midfall_rst_air: got %b want 00", air_state); end
    n_cmp++; if (pos_y !== 10'd447) begin n_bad++; $display("FAIL midfall_rst_y: got %0d want 447", pos_y); end
    n_cmp++; if (pos_x !== 10'd32) begin n_bad++; $display("FAIL midfall_rst_x: got %0d want 32", pos_x); end
    n_cmp++; if (landed !== 1'b0) begin n_bad++; $display("FAIL midfall_rst_landed: got %b want 0", landed); end
    n_cmp++; if (air_state_c !== 2'b00 || pos_y_c !== 10'd20) begin n_bad++; $display("FAIL midfall_rst_c: got %b/%0d want 00/20", air_state_c, pos_y_c); end
  endtask

  task automatic test_double_jump();
    logic [9:0] prev;
    do_reset();
    jump_key = 1'b1; step(); jump_key = 1'b0;
    for (int c = 0; c < 100 && air_state !== 2'b11; c++) step();
    n_cmp++; if (air_state !== 2'b11 || pos_y !== 10'd411) begin n_bad++; $display("FAIL dj_apex: got %b/%0d want 11/411", air_state, pos_y); end
    jump_key = 1'b1; step();
    n_cmp++; if (air_state !== EXP_AIR_JUMP) begin n_bad++; $display("FAIL dj_second_air: got %b want %b", air_state, EXP_AIR_JUMP); end
    prev = pos_y;
    for (int c = 0; c < 20 && pos_y === prev; c++) step();
    n_cmp++; if (pos_y !== 10'(EXP_Y_AFTER)) begin n_bad++; $display("FAIL dj_second_y: got %0d want %0d", pos_y, EXP_Y_AFTER); end
    jump_key = 1'b0; step();
    for (int c = 0; c < 100 && air_state !== 2'b11; c++) step();
    jump_key = 1'b1; step();
    n_cmp++; if (air_state !== 2'b11) begin n_bad++; $display("FAIL dj_third_ignored: got %b want 11", air_state); end
    jump_key = 1'b0;
    for (int c = 0; c < 200 && air_state !== 2'b00; c++) step();
    n_cmp++; if (air_state !== 2'b00 || pos_y !== 10'd447) begin n_bad++; $display("FAIL dj_land: got %b/%0d want 00/447", air_state, pos_y); end
    jump_key = 1'b1; step(); jump_key = 1'b0;
    n_cmp++; if (air_state !== 2'b10) begin n_bad++; $display("FAIL dj_rejump_ground: got %b want 10", air_state); end
    for (int c = 0; c < 100 && air_state !== 2'b11; c++) step();
    jump_key = 1'b1; step(); jump_key = 1'b0;
    n_cmp++; if (air_state !== EXP_AIR_JUMP) begin n_bad++; $display("FAIL dj_flag_cleared: got %b want %b", air_state, EXP_AIR_JUMP); end
  endtask

  initial begin
    test_reset();
    test_horizontal();
    test_jump();
    test_ceiling();
    test_reset_mid_fall();
    test_double_jump();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
